// File: rtl/vco_sweep_pkg.sv
// ----------------------------------------------------------------------------
// vco_sweep_pkg
//
// Shared definitions for the VCO sweep controller:
//   - default tuning-word and dwell-counter widths
//   - the sweep state enumeration
//   - sat_step(), the saturating up/down step used to walk the tuning word
//
// Optional feature macro: VCO_SWEEP_TRIANGLE_EN
//   When defined, the state enum gains ST_DOWN for the descending half of a
//   triangle sweep. When undefined, the controller is a plain ramp/sawtooth.
// ----------------------------------------------------------------------------
package vco_sweep_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int CW_DEFAULT = 16;

    // Working width of sat_step(). Callers zero-extend into it and truncate
    // the result back to their own word width, so any DW up to 31 works.
    localparam int SAT_W = 32;

`ifdef VCO_SWEEP_TRIANGLE_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DWELL = 3'd1,
        ST_STEP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DOWN  = 3'd4
    } sweep_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DWELL = 3'd1,
        ST_STEP  = 3'd2,
        ST_DONE  = 3'd3
    } sweep_state_t;
`endif

    // Saturating step of a width-bit word.
    //   up=1 : cur+step, clamped to limit when it reaches/passes limit or
    //          carries out of width bits.
    //   up=0 : cur-step, clamped to limit when it reaches/passes limit or
    //          would go below zero.
    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] cur,
        input logic [SAT_W-1:0] step,
        input logic [SAT_W-1:0] limit,
        input int               width,
        input logic             up
    );
        logic [SAT_W:0]   sum;
        logic [SAT_W:0]   span;
        logic [SAT_W-1:0] result;
        sum    = '0;
        span   = {{SAT_W{1'b0}}, 1'b1} << width;
        result = limit;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, step};
            if ((sum >= span) || (sum[SAT_W-1:0] >= limit)) begin
                result = limit;
            end else begin
                result = sum[SAT_W-1:0];
            end
        end else begin
            if ((cur < step) || ((cur - step) <= limit)) begin
                result = limit;
            end else begin
                result = cur - step;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vco_sweep_ctrl_dwell_timer.sv
// ----------------------------------------------------------------------------
// vco_dwell_timer
//
// Down-counter that times how long each tuning word is held. Loading a value
// N makes the word last N+1 cycles: the count sits at N on the first cycle
// and reaches zero on the last.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset, clears the count
//   load       - load load_value this cycle (takes priority over counting)
//   load_value - dwell count for the word being presented next
//   tc         - terminal count: this is the final cycle of the word
//   almost     - next cycle will be the final cycle of the word
// ----------------------------------------------------------------------------
module vco_dwell_timer #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          tc,
    output logic          almost
);

    logic [CW-1:0] count;

    // Counts down to zero and parks there until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc     = (count == '0);
    assign almost = (count == CW'(1));

endmodule

// File: rtl/vco_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// vco_sweep_ctrl
//
// Steps a VCO tuning word from a start word to a stop word, holding each word
// for a programmable number of cycles. Supports single or continuous sweeps,
// abort, and (optionally) a triangle sweep that walks back down to start.
//
// Optional feature macro: VCO_SWEEP_TRIANGLE_EN (adds the DOWN phase).
//
// Parameters:
//   DW - tuning word width
//   CW - dwell counter width
//
// Ports:
//   i_clk          - clock, rising edge
//   i_reset        - synchronous active-high reset
//   i_start        - sweep request pulse (accepted only when idle)
//   i_abort        - terminate the sweep; beats a simultaneous i_start
//   i_start_word   - first tuning word
//   i_stop_word    - last tuning word of the ramp
//   i_step         - increment per step (0 is treated as 1)
//   i_dwell        - each word is held i_dwell+1 cycles
//   i_continuous   - repeat the sweep until aborted
//   o_tune         - tuning word to the VCO
//   o_step_strobe  - one-cycle pulse whenever o_tune takes a new word
//   o_busy         - sweep in progress
//   o_done         - one-cycle pulse at normal completion
// ----------------------------------------------------------------------------
module vco_sweep_ctrl
    import vco_sweep_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [DW-1:0] i_start_word,
    input  logic [DW-1:0] i_stop_word,
    input  logic [DW-1:0] i_step,
    input  logic [CW-1:0] i_dwell,
    input  logic          i_continuous,
    output logic [DW-1:0] o_tune,
    output logic          o_step_strobe,
    output logic          o_busy,
    output logic          o_done
);

    sweep_state_t  state, state_n;
    logic [DW-1:0] tune, tune_n;
    logic          strobe, strobe_n;
    logic          busy, busy_n;
    logic          done, done_n;

    logic [DW-1:0] cfg_start;
    logic [DW-1:0] cfg_stop;
    logic [DW-1:0] cfg_step;
    logic [CW-1:0] cfg_dwell;
    logic          cfg_cont;

    logic          latch;
    logic          finish;
    sweep_state_t  first_state;
    logic          timer_load;
    logic [CW-1:0] timer_value;
    logic          timer_tc;
    logic          timer_almost;

    vco_dwell_timer #(
        .CW (CW)
    ) u_dwell_timer (
        .clk        (i_clk),
        .reset      (i_reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc),
        .almost     (timer_almost)
    );

    // Configuration is captured once at sweep start so that changes on the
    // inputs mid-sweep have no effect. A zero step is stored as one so the
    // ramp always makes progress.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cfg_start <= '0;
            cfg_stop  <= '0;
            cfg_step  <= DW'(1);
            cfg_dwell <= '0;
            cfg_cont  <= 1'b0;
        end else if (latch) begin
            cfg_start <= i_start_word;
            cfg_stop  <= i_stop_word;
            cfg_step  <= (i_step == '0) ? DW'(1) : i_step;
            cfg_dwell <= i_dwell;
            cfg_cont  <= i_continuous;
        end
    end

    // State and output registers. All outputs are registered so that a new
    // word, its strobe and the busy/done flags change on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= ST_IDLE;
            tune   <= '0;
            strobe <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            tune   <= tune_n;
            strobe <= strobe_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next-state logic. DWELL holds an ascending word; STEP is the final
    // cycle of an ascending word, where the following word is chosen so it
    // appears with no gap. A zero dwell skips DWELL and lands straight in
    // STEP. DOWN holds each descending word of a triangle sweep and checks
    // the timer's terminal count itself. Reaching the end of the sweep raises
    // 'finish', which is resolved after the case into a wrap or a done pulse.
    always_comb begin
        state_n     = state;
        tune_n      = tune;
        strobe_n    = 1'b0;
        busy_n      = busy;
        done_n      = 1'b0;
        latch       = 1'b0;
        finish      = 1'b0;
        timer_load  = 1'b0;
        timer_value = cfg_dwell;
        first_state = (cfg_dwell == '0) ? ST_STEP : ST_DWELL;

        case (state)
            ST_IDLE: begin
                busy_n = 1'b0;
                if (i_start && !i_abort) begin
                    latch       = 1'b1;
                    tune_n      = i_start_word;
                    strobe_n    = 1'b1;
                    busy_n      = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = i_dwell;
                    state_n     = (i_dwell == '0) ? ST_STEP : ST_DWELL;
                end
            end

            ST_DWELL: begin
                if (i_abort) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end else if (timer_almost) begin
                    state_n = ST_STEP;
                end
            end

            ST_STEP: begin
                if (i_abort) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end else if (tune < cfg_stop) begin
                    tune_n     = DW'(sat_step(SAT_W'(tune), SAT_W'(cfg_step),
                                              SAT_W'(cfg_stop), DW, 1'b1));
                    strobe_n   = 1'b1;
                    timer_load = 1'b1;
                    state_n    = first_state;
`ifdef VCO_SWEEP_TRIANGLE_EN
                end else if (tune > cfg_start) begin
                    tune_n     = DW'(sat_step(SAT_W'(tune), SAT_W'(cfg_step),
                                              SAT_W'(cfg_start), DW, 1'b0));
                    strobe_n   = 1'b1;
                    timer_load = 1'b1;
                    state_n    = ST_DOWN;
`endif
                end else begin
                    finish = 1'b1;
                end
            end

`ifdef VCO_SWEEP_TRIANGLE_EN
            ST_DOWN: begin
                if (i_abort) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end else if (timer_tc) begin
                    if (tune <= cfg_start) begin
                        finish = 1'b1;
                    end else begin
                        tune_n     = DW'(sat_step(SAT_W'(tune), SAT_W'(cfg_step),
                                                  SAT_W'(cfg_start), DW, 1'b0));
                        strobe_n   = 1'b1;
                        timer_load = 1'b1;
                        state_n    = ST_DOWN;
                    end
                end
            end
`endif

            ST_DONE: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase

        // End of sweep: continuous mode restarts at the start word with a
        // fresh strobe; otherwise pulse done and drop busy together.
        if (finish) begin
            if (cfg_cont) begin
                tune_n     = cfg_start;
                strobe_n   = 1'b1;
                timer_load = 1'b1;
                state_n    = first_state;
            end else begin
                state_n = ST_DONE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
            end
        end
    end

    assign o_tune        = tune;
    assign o_step_strobe = strobe;
    assign o_busy        = busy;
    assign o_done        = done;

endmodule

// File: tb/tb_vco_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vco_sweep_ctrl
//
// Directed self-checking bench for vco_sweep_ctrl. Inputs are driven and
// outputs sampled on the falling clock edge. Expected word sequences follow
// the build: with VCO_SWEEP_TRIANGLE_EN defined the descending half is added.
// ----------------------------------------------------------------------------
module tb_vco_sweep_ctrl;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [DW-1:0] start_word;
    logic [DW-1:0] stop_word;
    logic [DW-1:0] step;
    logic [CW-1:0] dwell;
    logic          continuous;
    logic [DW-1:0] tune;
    logic          step_strobe;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    // Results of the most recent capture()
    int words[$];
    int lens[$];
    int busy_cycles;
    bit saw_done;
    bit strobe_ok;
    bit timed_out;

    vco_sweep_ctrl #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_abort       (abort),
        .i_start_word  (start_word),
        .i_stop_word   (stop_word),
        .i_step        (step),
        .i_dwell       (dwell),
        .i_continuous  (continuous),
        .o_tune        (tune),
        .o_step_strobe (step_strobe),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    // Issues a one-cycle start with the given configuration, then scrambles
    // the configuration inputs so a controller that fails to latch them shows
    // it. Returns at the falling edge where the first word should be visible.
    task automatic begin_sweep(input logic [DW-1:0] s, input logic [DW-1:0] e,
                               input logic [DW-1:0] st, input logic [CW-1:0] d,
                               input logic c);
        @(negedge clk);
        start_word = s;
        stop_word  = e;
        step       = st;
        dwell      = d;
        continuous = c;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        start_word = 8'hA5;
        stop_word  = 8'h11;
        step       = 8'h03;
        dwell      = 16'd7;
        continuous = ~c;
    endtask

    // Records the word sequence and per-word hold lengths while busy, stopping
    // at the done pulse or when busy drops. Optionally keeps i_start high the
    // whole time to show that starts are ignored while busy.
    task automatic capture(input int limit, input bit spam);
        words.delete();
        lens.delete();
        busy_cycles = 0;
        saw_done    = 1'b0;
        strobe_ok   = 1'b1;
        timed_out   = 1'b1;
        for (int c = 0; c < limit; c++) begin
            if (done) begin
                saw_done  = 1'b1;
                timed_out = 1'b0;
                break;
            end
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            busy_cycles++;
            if (step_strobe) begin
                words.push_back(int'(tune));
                lens.push_back(1);
            end else if (words.size() == 0 || int'(tune) != words[words.size()-1]) begin
                strobe_ok = 1'b0;
                words.push_back(int'(tune));
                lens.push_back(1);
            end else begin
                lens[lens.size()-1]++;
            end
            start = spam;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        start_word = 8'd9;
        stop_word  = 8'd20;
        step       = 8'd1;
        dwell      = 16'd0;
        continuous = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tune !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_tune got %0d expected 0", tune);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || step_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got busy=%b done=%b strobe=%b expected 0 0 0",
                     busy, done, step_strobe);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tune !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_idle got busy=%b tune=%0d expected 0 0", busy, tune);
        end
    endtask

    task automatic test_ramp();
        int exp_w[$];
`ifdef VCO_SWEEP_TRIANGLE_EN
        exp_w = '{10, 20, 30, 40, 30, 20, 10};
`else
        exp_w = '{10, 20, 30, 40};
`endif
        begin_sweep(8'd10, 8'd40, 8'd10, 16'd2, 1'b0);
        capture(200, 1'b1);
        checks++;
        if (timed_out || !saw_done) begin
            errors++;
            $display("[TB] FAIL ramp_done got timeout=%b done=%b expected 0 1", timed_out, saw_done);
        end
        checks++;
        if (words.size() != exp_w.size()) begin
            errors++;
            $display("[TB] FAIL ramp_count got %0d expected %0d", words.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < words.size(); i++) begin
            checks++;
            if (words[i] != exp_w[i] || lens[i] != 3) begin
                errors++;
                $display("[TB] FAIL ramp_word[%0d] got %0d x%0d expected %0d x3",
                         i, words[i], lens[i], exp_w[i]);
            end
        end
        checks++;
        if (busy_cycles != 3 * exp_w.size() || !strobe_ok) begin
            errors++;
            $display("[TB] FAIL ramp_busy got %0d cycles strobe_ok=%b expected %0d 1",
                     busy_cycles, strobe_ok, 3 * exp_w.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ramp_busy_at_done got %b expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || tune !== 8'(exp_w[exp_w.size()-1])) begin
            errors++;
            $display("[TB] FAIL ramp_after got done=%b busy=%b tune=%0d expected 0 0 %0d",
                     done, busy, tune, exp_w[exp_w.size()-1]);
        end
    endtask

    task automatic test_overflow();
        int exp_w[$];
`ifdef VCO_SWEEP_TRIANGLE_EN
        exp_w = '{250, 255, 250};
`else
        exp_w = '{250, 255};
`endif
        begin_sweep(8'd250, 8'd255, 8'd10, 16'd1, 1'b0);
        capture(200, 1'b0);
        checks++;
        if (timed_out || !saw_done || words.size() != exp_w.size()) begin
            errors++;
            $display("[TB] FAIL ovf_shape got timeout=%b done=%b words=%0d expected 0 1 %0d",
                     timed_out, saw_done, words.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < words.size(); i++) begin
            checks++;
            if (words[i] != exp_w[i] || lens[i] != 2) begin
                errors++;
                $display("[TB] FAIL ovf_word[%0d] got %0d x%0d expected %0d x2",
                         i, words[i], lens[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_degenerate();
        int exp_w[$];
        // stop below start: one word at start, held dwell+1 = 4 cycles
        begin_sweep(8'd50, 8'd20, 8'd5, 16'd3, 1'b0);
        capture(200, 1'b0);
        checks++;
        if (!saw_done || words.size() != 1 || busy_cycles != 4) begin
            errors++;
            $display("[TB] FAIL single_shape got done=%b words=%0d busy=%0d expected 1 1 4",
                     saw_done, words.size(), busy_cycles);
        end
        checks++;
        if (words.size() > 0 && words[0] != 50) begin
            errors++;
            $display("[TB] FAIL single_word got %0d expected 50", words[0]);
        end
        @(negedge clk);
        // zero step behaves as one, zero dwell holds each word one cycle
`ifdef VCO_SWEEP_TRIANGLE_EN
        exp_w = '{0, 1, 2, 3, 2, 1, 0};
`else
        exp_w = '{0, 1, 2, 3};
`endif
        begin_sweep(8'd0, 8'd3, 8'd0, 16'd0, 1'b0);
        capture(200, 1'b0);
        checks++;
        if (!saw_done || words.size() != exp_w.size() || !strobe_ok) begin
            errors++;
            $display("[TB] FAIL step0_shape got done=%b words=%0d strobe_ok=%b expected 1 %0d 1",
                     saw_done, words.size(), strobe_ok, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < words.size(); i++) begin
            checks++;
            if (words[i] != exp_w[i] || lens[i] != 1) begin
                errors++;
                $display("[TB] FAIL step0_word[%0d] got %0d x%0d expected %0d x1",
                         i, words[i], lens[i], exp_w[i]);
            end
        end
    endtask

`ifdef VCO_SWEEP_TRIANGLE_EN
    task automatic test_triangle();
        int exp_w[$];
        exp_w = '{0, 1, 2, 3, 2, 1, 0};
        begin_sweep(8'd0, 8'd3, 8'd1, 16'd0, 1'b0);
        capture(200, 1'b0);
        checks++;
        if (!saw_done || words.size() != exp_w.size() || busy_cycles != 7) begin
            errors++;
            $display("[TB] FAIL tri_shape got done=%b words=%0d busy=%0d expected 1 7 7",
                     saw_done, words.size(), busy_cycles);
        end
        for (int i = 0; i < exp_w.size() && i < words.size(); i++) begin
            checks++;
            if (words[i] != exp_w[i]) begin
                errors++;
                $display("[TB] FAIL tri_word[%0d] got %0d expected %0d", i, words[i], exp_w[i]);
            end
        end
    endtask
`endif

    task automatic test_continuous_abort();
        int exp_w[$];
`ifdef VCO_SWEEP_TRIANGLE_EN
        exp_w = '{0, 1, 2, 1, 0, 0, 1};
`else
        exp_w = '{0, 1, 2, 0, 1, 2, 0, 1};
`endif
        begin_sweep(8'd0, 8'd2, 8'd1, 16'd0, 1'b1);
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (tune !== 8'(exp_w[i]) || step_strobe !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cont_cycle[%0d] got tune=%0d strobe=%b busy=%b done=%b expected %0d 1 1 0",
                         i, tune, step_strobe, busy, done, exp_w[i]);
            end
            if (i == exp_w.size() - 1) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || tune !== 8'd1 || done !== 1'b0 || step_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_next got busy=%b tune=%0d done=%b strobe=%b expected 0 1 0 0",
                     busy, tune, done, step_strobe);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || tune !== 8'd1 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_hold[%0d] got busy=%b tune=%0d done=%b expected 0 1 0",
                         i, busy, tune, done);
            end
        end
    endtask

    task automatic test_start_abort_reset();
        // start and abort together while idle: abort wins
        start_word = 8'd10;
        stop_word  = 8'd40;
        step       = 8'd10;
        dwell      = 16'd2;
        continuous = 1'b0;
        start      = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || step_strobe !== 1'b0 || tune !== 8'd1) begin
            errors++;
            $display("[TB] FAIL start_abort got busy=%b strobe=%b tune=%0d expected 0 0 1",
                     busy, step_strobe, tune);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_abort_idle got busy=%b expected 0", busy);
        end
        // reset mid-sweep, with a simultaneous start
        begin_sweep(8'd10, 8'd40, 8'd10, 16'd2, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (tune !== 8'd20 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midsweep got tune=%0d busy=%b expected 20 1", tune, busy);
        end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (tune !== 8'd0 || busy !== 1'b0 || step_strobe !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid got tune=%0d busy=%b strobe=%b done=%b expected 0 0 0 0",
                     tune, busy, step_strobe, done);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (tune !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_after got tune=%0d busy=%b expected 0 0", tune, busy);
        end
    endtask

    initial begin
        $display("[TB] vco_sweep_ctrl directed tests");
        test_reset();
        test_ramp();
        test_overflow();
        test_degenerate();
`ifdef VCO_SWEEP_TRIANGLE_EN
        test_triangle();
`endif
        test_continuous_abort();
        test_start_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vco_sweep_ctrl.md
VCO_SWEEP_CTRL -- requirements
Module: vco_sweep_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: tuning word width, equal to the vco i_data width.
REQ-002 SHALL have parameter CW, default 16: dwell counter width.
REQ-003 SHALL have port i_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_start, input, 1: sweep request pulse.
REQ-006 SHALL have port i_abort, input, 1: terminate the sweep.
REQ-007 SHALL have port i_start_word, input, DW: first tuning word.
REQ-008 SHALL have port i_stop_word, input, DW: sweep end word.
REQ-009 SHALL have port i_step, input, DW: increment per step.
REQ-010 SHALL have port i_dwell, input, CW: hold count per word.
REQ-011 SHALL have port i_continuous, input, 1: repeat the sweep until abort.
REQ-012 SHALL have port o_tune, output, DW: tuning word; drives vco i_data.
REQ-013 SHALL have port o_step_strobe, output, 1: 1-cycle pulse when o_tune takes a new word.
REQ-014 SHALL have port o_busy, output, 1: sweep in progress.
REQ-015 SHALL have port o_done, output, 1: 1-cycle pulse at normal sweep completion.

Function
REQ-016 SHALL implement states IDLE, DWELL, STEP and DONE, plus DOWN when the triangle feature is compiled in.
REQ-017 SHALL, in IDLE, latch all configuration inputs when i_start=1 and i_abort=0, then enter DWELL on the next cycle with o_tune=i_start_word, o_step_strobe=1 and o_busy=1.
REQ-018 SHALL hold each word for exactly i_dwell+1 cycles; i_dwell=0 gives 1 cycle.
REQ-019 SHALL, in STEP, compute next=cur+step in DW+1 bits; if next>=stop or next overflows DW bits, o_tune=stop; otherwise o_tune=next.
REQ-020 SHALL treat a latched step of 0 as 1.
REQ-021 SHALL, when latched stop<=start, produce a single-word sweep at start.
REQ-022 SHALL, after the dwell on stop ends with i_continuous=0, assert o_done for 1 cycle, drop o_busy in that same cycle and return to IDLE.
REQ-023 SHALL, with i_continuous=1, wrap to start after the stop dwell with o_step_strobe=1, never assert o_done, and keep o_busy=1.
REQ-024 SHALL, on i_abort while busy, reach IDLE on the next cycle with o_busy=0, o_done=0 and o_tune held.
REQ-025 SHALL give i_abort priority over a simultaneous i_start.
REQ-026 SHALL ignore i_start while busy.
REQ-027 SHALL hold o_tune at the last word in IDLE.
REQ-028 SHALL ignore configuration input changes mid-sweep.
REQ-029 SHALL insert no idle cycle between words: the cycle after a dwell ends presents the next word.

Reset
REQ-030 SHALL, on i_reset=1 at a clock edge, set state=IDLE, o_tune=0, o_step_strobe=0, o_busy=0, o_done=0 and the dwell counter to 0.
REQ-031 SHALL let reset mid-sweep override everything, including a simultaneous i_start.

Configuration
REQ-032 SHALL, with macro VCO_SWEEP_TRIANGLE_EN defined, enter DOWN after the stop dwell and step down by step, saturating at start (next<=start or underflow gives start), then apply the REQ-022/REQ-023 completion rules after the start dwell.
REQ-033 SHALL, in triangle mode, not repeat the peak word: stop and the first down word are distinct dwells.
REQ-034 SHALL, without VCO_SWEEP_TRIANGLE_EN, omit DOWN and behave as a sawtooth/single ramp.

Structure
REQ-035 SHALL place the state enum, default DW/CW constants and the saturating step function in shared package vco_sweep_pkg.
REQ-036 SHALL implement dwell counting in sub-module vco_dwell_timer (load value, terminal-count output), instantiated once.

Verification
REQ-037 SHALL test: start=10, stop=40, step=10, dwell=2, single -> o_tune 10,20,30,40 each 3 cycles, strobes at each change, o_done 1 cycle after 12th busy cycle.
REQ-038 SHALL test: start=250, stop=255, step=10 -> words 250,255 (overflow saturates), then done.
REQ-039 SHALL test: start=50, stop=20 -> single word 50, o_done after dwell+1 cycles; step=0 with start=0, stop=3, dwell=0 -> 0,1,2,3.
REQ-040 SHALL test: continuous, start=0, stop=2, step=1, dwell=0 -> 0,1,2,0,1,2...; abort at word 1 -> o_busy=0 next cycle, o_tune=1, no o_done.
REQ-041 SHALL test: i_start and i_abort in the same IDLE cycle -> stays IDLE; i_reset mid-sweep -> o_tune=0, o_busy=0 next cycle.
REQ-042 SHALL test, with VCO_SWEEP_TRIANGLE_EN defined: start=0, stop=3, step=1, dwell=0 -> 0,1,2,3,2,1,0, then o_done.
